// File: rtl/ramfetch_pkg.sv
// rtl/ramfetch_pkg.sv - shared states, size codes and size decode for ramfetch
package ramfetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  function automatic logic [3:0] sz_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/ramfetch_lane.sv
// rtl/ramfetch_lane.sv - 64-bit byte-lane assembly register; RAMFETCH_SIGN_EXT_EN adds sign fill
module ramfetch_lane
  import ramfetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        we,
  input  logic [2:0]  sel,
  input  logic [7:0]  din,
`ifdef RAMFETCH_SIGN_EXT_EN
  input  logic        ext,
`endif
  output logic [63:0] q
);

  logic [63:0] nxt;

  always_comb begin
    nxt = q;
    if (we) begin
      nxt[{sel, 3'b000} +: 8] = din;
`ifdef RAMFETCH_SIGN_EXT_EN
      // ext accompanies the last byte, so its msb is the sign for every lane above it
      for (int i = 1; i < 8; i++) begin
        if (ext && (i > int'(sel))) nxt[i*8 +: 8] = {8{din[7]}};
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else          q <= nxt;
  end

endmodule

// File: rtl/ramfetch.sv
// rtl/ramfetch.sv - byte-serial RAM read sequencer assembling a little-endian 64-bit word
// Optional sign extension of narrow loads under RAMFETCH_SIGN_EXT_EN.
module ramfetch
  import ramfetch_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int AW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    sz,
  input  logic [AW-1:0] add,
`ifdef RAMFETCH_SIGN_EXT_EN
  input  logic          sx,
`endif
  input  logic [7:0]    rdata,
  output logic          re,
  output logic [AW-1:0] adq,
  output logic          kp,
  output logic [63:0]   q,
  output logic          valid
);

  state_t            state;
  logic [3:0]        n;
  logic [3:0]        ic;
  logic [3:0]        cc;
  logic [RD_LAT-1:0] pipe;
  logic              cap;
  logic              last;

  assign cap  = pipe[RD_LAT-1] && ((state == ISSUE) || (state == DRAIN));
  assign last = cap && (cc == n - 4'd1);

`ifdef RAMFETCH_SIGN_EXT_EN
  logic sx_r;

  always_ff @(posedge clk) begin
    if (!rst_n)                          sx_r <= 1'b0;
    else if ((state == IDLE) && start)   sx_r <= sx;
  end
`endif

  ramfetch_lane u_lane (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state == IDLE) && start),
    .we    (cap),
    .sel   (cc[2:0]),
    .din   (rdata),
`ifdef RAMFETCH_SIGN_EXT_EN
    .ext   (sx_r && last),
`endif
    .q     (q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      re    <= 1'b0;
      adq   <= '0;
      kp    <= 1'b0;
      valid <= 1'b0;
      n     <= '0;
      ic    <= '0;
      cc    <= '0;
      pipe  <= '0;
    end else begin
      // re is the issue flag entering the in-flight tracker
      pipe  <= (pipe << 1) | RD_LAT'(re);
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n     <= sz_bytes(sz);
            ic    <= '0;
            cc    <= '0;
            kp    <= 1'b1;
            re    <= 1'b1;
            adq   <= add;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (ic == n - 4'd1) begin
            re    <= 1'b0;
            state <= DRAIN;
          end else begin
            ic  <= ic + 4'd1;
            adq <= adq + AW'(1);
          end
        end
        DRAIN: ;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
      if (cap) cc <= cc + 4'd1;
      if (last) begin
        state <= DONE;
        valid <= 1'b1;
        kp    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ramfetch.sv
// tb/tb_ramfetch.sv - directed bench for ramfetch at RD_LAT=1 and RD_LAT=3
module tb_ramfetch;
  import ramfetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, use3, sx;
  logic [1:0]  sz;
  logic [15:0] add;
  logic        start1, start3;
  logic        re1, re3, kp1, kp3, v1, v3;
  logic [15:0] adq1, adq3;
  logic [63:0] q1, q3;
  logic [7:0]  rd1, rd3;
  logic [7:0]  mem [0:65535];
  logic [7:0]  p1;
  logic [7:0]  p3 [3];

  assign start1 = start & ~use3;
  assign start3 = start & use3;

  always @(posedge clk) begin
    p1    <= re1 ? mem[adq1] : 8'h00;
    p3[0] <= re3 ? mem[adq3] : 8'h00;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rd1 = p1;
  assign rd3 = p3[2];

  ramfetch #(.RD_LAT(1), .AW(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sz(sz), .add(add),
`ifdef RAMFETCH_SIGN_EXT_EN
    .sx(sx),
`endif
    .rdata(rd1), .re(re1), .adq(adq1), .kp(kp1), .q(q1), .valid(v1)
  );

  ramfetch #(.RD_LAT(3), .AW(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .sz(sz), .add(add),
`ifdef RAMFETCH_SIGN_EXT_EN
    .sx(sx),
`endif
    .rdata(rd3), .re(re3), .adq(adq3), .kp(kp3), .q(q3), .valid(v3)
  );

  logic        re_o, kp_o, v_o;
  logic [15:0] adq_o;
  logic [63:0] q_o;
  assign re_o  = use3 ? re3  : re1;
  assign kp_o  = use3 ? kp3  : kp1;
  assign v_o   = use3 ? v3   : v1;
  assign adq_o = use3 ? adq3 : adq1;
  assign q_o   = use3 ? q3   : q1;

  int          checks = 0;
  int          errors = 0;
  int          vcyc, nval, kcnt;
  logic [63:0] vq;
  logic        re_log  [0:31];
  logic        kp_log  [0:31];
  logic [15:0] adq_log [0:31];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered just after a posedge; start is high for cycle 0 and optionally again in cycle pulse_k.
  task automatic do_load(input logic u, input logic [1:0] s, input logic [15:0] a,
                         input logic x, input int pulse_k);
    use3 = u; sz = s; add = a; sx = x; start = 1'b1;
    vcyc = -1; nval = 0; vq = '0; kcnt = 0;
    @(negedge clk);
    re_log[0] = re_o; kp_log[0] = kp_o; adq_log[0] = adq_o;
    for (int k = 1; k < 32; k++) begin
      @(posedge clk); #1;
      start = (k == pulse_k);
      @(negedge clk);
      re_log[k] = re_o; kp_log[k] = kp_o; adq_log[k] = adq_o;
      if (kp_o) kcnt++;
      if (v_o) begin
        nval++;
        if (vcyc < 0) begin vcyc = k; vq = q_o; end
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem[16'h0010 + i] = 8'(8'h11 * (i + 1));
    mem[16'hFFFE] = 8'hAA; mem[16'hFFFF] = 8'hBB;
    mem[16'h0000] = 8'hCC; mem[16'h0001] = 8'hDD;
    mem[16'h0020] = 8'h80;

    rst_n = 1'b0; start = 1'b0; use3 = 1'b0; sz = 2'b00; add = '0; sx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_re1", re1, 0);    chk("rst_adq1", adq1, 0); chk("rst_kp1", kp1, 0);
    chk("rst_q1", q1, 0);      chk("rst_valid1", v1, 0);
    chk("rst_re3", re3, 0);    chk("rst_kp3", kp3, 0);   chk("rst_q3", q3, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8-byte load, RD_LAT=1
    do_load(1'b0, SZ_D, 16'h0010, 1'b0, 0);
    chk("t1_valid_cycle", vcyc, 10);
    chk("t1_q", vq, 64'h8877665544332211);
    chk("t1_valid_count", nval, 1);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("t1_re_%0d", k), re_log[k], 1);
      chk($sformatf("t1_adq_%0d", k), adq_log[k], 16'h0010 + k - 1);
    end
    chk("t1_re_after", re_log[9], 0);
    chk("t1_kp_c0", kp_log[0], 0);
    chk("t1_kp_c1", kp_log[1], 1);
    chk("t1_kp_c9", kp_log[9], 1);
    chk("t1_kp_c10", kp_log[10], 0);
    chk("t1_kp_cycles", kcnt, 9);
    chk("t1_q_hold", q1, 64'h8877665544332211);

    // 2-byte load
    do_load(1'b0, SZ_H, 16'h0012, 1'b0, 0);
    chk("t2_valid_cycle", vcyc, 4);
    chk("t2_q", vq, 64'h0000000000004433);

    // address wrap
    do_load(1'b0, SZ_W, 16'hFFFE, 1'b0, 0);
    chk("t3_adq_1", adq_log[1], 16'hFFFE);
    chk("t3_adq_2", adq_log[2], 16'hFFFF);
    chk("t3_adq_3", adq_log[3], 16'h0000);
    chk("t3_adq_4", adq_log[4], 16'h0001);
    chk("t3_valid_cycle", vcyc, 6);
    chk("t3_q", vq, 64'h00000000DDCCBBAA);

    // RD_LAT=3 single byte, start pulsed again while busy
    do_load(1'b1, SZ_B, 16'h0015, 1'b0, 2);
    chk("t4_valid_cycle", vcyc, 5);
    chk("t4_q", vq, 64'h66);
    chk("t4_valid_count", nval, 1);
    chk("t4_kp_cycles", kcnt, 4);

    // reset in cycle 4 of an 8-byte load
    use3 = 1'b0; sz = SZ_D; add = 16'h0010; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_q_partial", q1, 64'h2211);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t5_re", re1, 0); chk("t5_kp", kp1, 0);
    chk("t5_q", q1, 0);   chk("t5_valid", v1, 0);
    nval = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (v1) nval++;
    end
    chk("t5_no_valid", nval, 0);
    @(posedge clk); #1;
    do_load(1'b0, SZ_D, 16'h0010, 1'b0, 0);
    chk("t5_reload_cycle", vcyc, 10);
    chk("t5_reload_q", vq, 64'h8877665544332211);

`ifdef RAMFETCH_SIGN_EXT_EN
    do_load(1'b0, SZ_B, 16'h0020, 1'b1, 0);
    chk("t6_sx1_q", vq, 64'hFFFFFFFFFFFFFF80);
    do_load(1'b0, SZ_B, 16'h0020, 1'b0, 0);
    chk("t6_sx0_q", vq, 64'h80);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ramfetch.md
Name: ramfetch

Overview:
- Read-side counterpart of the byte-serial RAM write controller.
- Accepts a load request (base address, size), issues consecutive byte reads to the 8-bit RAM, and assembles the returned bytes little-endian into a 64-bit word.
- Holds the CPU stalled via kp while busy, then pulses valid with the assembled word.
- Sits between the CPU execute/load stage and the 8-bit data RAM read port.

Parameters:
- RD_LAT, 1, RAM read latency in cycles from re/adq to rdata valid; legal 1..3.
- AW, 16, address width.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  load request; sampled only in IDLE.
- sz  input  2  size code: 00=1 byte, 01=2 bytes, 10=4 bytes, 11=8 bytes.
- add  input  AW  base byte address; latched with start.
- rdata  input  8  byte returned by RAM, RD_LAT cycles after the read was issued.
- re  output  1  RAM read enable.
- adq  output  AW  RAM byte address.
- kp  output  1  stall/busy; high from the cycle after start until valid.
- q  output  64  assembled word; byte i in q[8i+7:8i].
- valid  output  1  one-cycle pulse: q complete.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values: re=0, adq=0, kp=0, q=0, valid=0, state=IDLE, all counters 0. Reset mid-operation aborts at once; in-flight RAM returns are discarded.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On start=1: latch add into an address register; set n = 1/2/4/8 from sz; clear q to 0; issue count ic=0; capture count cc=0; kp<=1; go to ISSUE.
  - With start=0: hold q and all other outputs.
- ISSUE: each cycle re=1 and adq=base+ic, mod 2^AW (0xFFFF wraps to 0x0000). ic increments; after issuing ic==n-1, go to DRAIN.
- Capture pipeline:
  - An RD_LAT-deep shift register of issue flags tracks reads in flight.
  - When the delayed flag is 1, rdata is written into byte lane cc of q and cc increments.
  - Capture runs in ISSUE and DRAIN.
- DRAIN: re=0, adq holds its last value. When cc reaches n, go to DONE.
- DONE (one cycle): valid=1, kp=0, go to IDLE.
- Timing: with start in cycle 0, reads issue in cycles 1..n and the last capture is in cycle n+RD_LAT. valid=1 and kp=0 in cycle n+RD_LAT+1, so total latency is n+RD_LAT+1.
- Unloaded upper bytes read 0 (see the optional feature).
- start while kp=1 or in DONE is ignored; there is no queueing. Back-to-back operation: start may be asserted in the cycle after valid.
- q is stable from valid until the next accepted start.

Optional Feature:
- RAMFETCH_SIGN_EXT_EN defined:
  - Adds input sx (1 bit), latched with start.
  - When sx=1 and n<8, DONE replicates bit 8n-1 of q into q[63:8n] in the same cycle valid is asserted.
- Not defined: port sx is absent and upper bytes stay zero.

Decomposition:
- Shared package/header (alongside the existing state defines):
  - state encodings IDLE/ISSUE/DRAIN/DONE;
  - size-code constants SZ_B/SZ_H/SZ_W/SZ_D;
  - size-to-byte-count function.
- One natural sub-module, ramfetch_lane: 64-bit assembly register with byte-lane write enable (and sign-extension under the macro).
- Sequencing and counters stay in ramfetch.

Test Plan:
- RAM preloaded 0x10..0x17 = 11 22 33 44 55 66 77 88; start, sz=11, add=0x0010, RD_LAT=1 -> adq 0x10..0x17 in cycles 1..8; valid at cycle 10 with q=0x8877665544332211; kp high cycles 1..9.
- Same RAM, sz=01, add=0x0012 -> q=0x0000000000004433; valid at cycle 4.
- Wrap: RAM[0xFFFE]=AA, RAM[0xFFFF]=BB, RAM[0x0000]=CC, RAM[0x0001]=DD; sz=10, add=0xFFFE -> adq FFFE,FFFF,0000,0001; q=0x00000000DDCCBBAA.
- RD_LAT=3, sz=00, add=0x0015 -> valid at cycle 5, q=0x66; start pulsed during kp is ignored (no second valid).
- rst_n=0 in cycle 4 of an 8-byte load -> next cycle re=0, kp=0, q=0, no valid; a new load afterwards completes correctly.
- With RAMFETCH_SIGN_EXT_EN, RAM[0x20]=0x80, sz=00, sx=1 -> q=0xFFFFFFFFFFFFFF80; with sx=0 -> q=0x80.
